lfsr_seq_ctrl: RTL and testbench

Sequencing controller for the 3-bit loadable feedback shift register (parallel load `R`/`L`, shift Q0←Q2, Q1←Q0, Q2←Q1^Q2, output `Qout`).

- Accepts commands over a valid/ready handshake and loads a seed.
- Either advances the register an exact number of steps or seeks a target pattern.
- Returns the final state over a second handshake.
- The register has no enable: with `L=0` it shifts on every clock. This block therefore holds the register, when not stepping it, by reloading its own output (`L=1`, `R=Qout`).

---
 rtl/lfsr_pkg.sv | 22 ++
 rtl/step_counter.sv | 34 +++
 rtl/lfsr_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 3-bit feedback shift register sequencer.
//   state_t   : controller state encoding
//   LFSR_W    : register width
//   SEED_FIX  : replacement seed for the all-zero lock-up state
//   lfsr_next : one shift of the register (Q0<-Q2, Q1<-Q0, Q2<-Q1^Q2)
package lfsr_pkg;

    localparam int LFSR_W = 3;
    localparam logic [LFSR_W-1:0] SEED_FIX = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[1] ^ q[2], q[0], q[2]};
    endfunction

endpackage

// File: rtl/step_counter.sv
// Up-counter for the number of shifts performed, with a limit compare.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : force count to zero (wins over inc)
//   inc       : advance count by one
//   limit     : value compared against count
//   count     : current shift count
//   at_limit  : count == limit
module step_counter #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [STEP_W-1:0] limit,
    output logic [STEP_W-1:0] count,
    output logic              at_limit
);

    localparam logic [STEP_W-1:0] ONE = STEP_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + ONE;
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencing controller for the 3-bit loadable feedback shift register.
// Accepts a command (seed plus either a step count or a target pattern),
// loads the register, steps it, and returns the final value.
//   clk, rst             : clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake
//   cmd_mode             : 0 = run cmd_steps shifts, 1 = seek cmd_target
//   cmd_seed/steps/target: command payload
//   lfsr_r, lfsr_l       : register parallel-load value and load select
//   lfsr_q               : register output
//   res_valid/res_ready  : result handshake
//   res_q/hit/steps      : final register value, seek hit flag, shift count
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | hold register, wait for a command
// LOAD  | parallel-load seed' into the register, clear the counter
// RUN   | shift once per cycle until target seen or limit reached
// DONE  | hold register, present result until consumed
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int STEP_W     = 8,
    parameter int SEEK_LIMIT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [LFSR_W-1:0] cmd_seed,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [LFSR_W-1:0] cmd_target,
    output logic [LFSR_W-1:0] lfsr_r,
    output logic              lfsr_l,
    input  logic [LFSR_W-1:0] lfsr_q,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [LFSR_W-1:0] res_q,
    output logic              res_hit,
    output logic [STEP_W-1:0] res_steps
);

    localparam logic [STEP_W-1:0] SEEK_LIM = STEP_W'(SEEK_LIMIT);

    state_t              state, state_nxt;
    logic                mode_r;
    logic [LFSR_W-1:0]   seed_r;
    logic [LFSR_W-1:0]   target_r;
    logic [STEP_W-1:0]   steps_r;

    logic                accept;
    logic                finish;
    logic                hit_nxt;
    logic                cnt_clr;
    logic                cnt_inc;
    logic                at_limit;
    logic [STEP_W-1:0]   count;
    logic [STEP_W-1:0]   limit;

    assign limit = mode_r ? SEEK_LIM : steps_r;

    step_counter #(.STEP_W(STEP_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .limit    (limit),
        .count    (count),
        .at_limit (at_limit)
    );

    // The register has no enable, so "hold" means reloading its own output.
    always_comb begin
        state_nxt = state;
        lfsr_l    = 1'b1;
        lfsr_r    = lfsr_q;
        accept    = 1'b0;
        finish    = 1'b0;
        hit_nxt   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                lfsr_r    = seed_r;
                cnt_clr   = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (mode_r && (lfsr_q == target_r)) begin
                    finish    = 1'b1;
                    hit_nxt   = 1'b1;
                    state_nxt = DONE;
                end else if (at_limit) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    lfsr_l  = 1'b0;
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            res_q     <= '0;
            res_hit   <= 1'b0;
            res_steps <= '0;
            mode_r    <= 1'b0;
            seed_r    <= SEED_FIX;
            target_r  <= '0;
            steps_r   <= '0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == IDLE);
            res_valid <= (state_nxt == DONE);
            if (accept) begin
                mode_r   <= cmd_mode;
                // All-zero is the lock-up state of this register.
                seed_r   <= (cmd_seed == '0) ? SEED_FIX : cmd_seed;
                target_r <= cmd_target;
                steps_r  <= cmd_steps;
            end
            if (finish) begin
                res_q     <= lfsr_q;
                res_hit   <= hit_nxt;
                res_steps <= count;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
module tb_lfsr_seq_ctrl;
    import lfsr_pkg::*;

    localparam int STEP_W     = 8;
    localparam int SEEK_LIMIT = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_mode = 1'b0;
    logic [2:0]        cmd_seed = '0;
    logic [STEP_W-1:0] cmd_steps = '0;
    logic [2:0]        cmd_target = '0;
    logic [2:0]        lfsr_r;
    logic              lfsr_l;
    logic [2:0]        lfsr_q = 3'b011;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [2:0]        res_q;
    logic              res_hit;
    logic [STEP_W-1:0] res_steps;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] period [7] = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b111, 3'b011, 3'b110};

    lfsr_seq_ctrl #(.STEP_W(STEP_W), .SEEK_LIMIT(SEEK_LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_seed   (cmd_seed),
        .cmd_steps  (cmd_steps),
        .cmd_target (cmd_target),
        .lfsr_r     (lfsr_r),
        .lfsr_l     (lfsr_l),
        .lfsr_q     (lfsr_q),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_q      (res_q),
        .res_hit    (res_hit),
        .res_steps  (res_steps)
    );

    always #5 clk = ~clk;

    function automatic int pidx(input logic [2:0] q);
        for (int i = 0; i < 7; i++) begin
            if (period[i] == q) return i;
        end
        return -1;
    endfunction

    // Register datapath model: walks the known period sequence.
    always @(posedge clk) begin
        if (lfsr_l)
            lfsr_q <= lfsr_r;
        else if (lfsr_q != 3'b000)
            lfsr_q <= period[(pidx(lfsr_q) + 1) % 7];
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected result from position arithmetic on the period sequence.
    task automatic ref_model(input logic mode, input logic [2:0] seed, input int steps,
                             input logic [2:0] tgt, output logic [2:0] q,
                             output logic hit, output int st, output int lat);
        logic [2:0] s;
        s = (seed == 3'b000) ? 3'b001 : seed;
        if (!mode) begin
            q   = period[(pidx(s) + steps) % 7];
            hit = 1'b0;
            st  = steps;
        end else if (tgt == 3'b000) begin
            q   = period[(pidx(s) + SEEK_LIMIT) % 7];
            hit = 1'b0;
            st  = SEEK_LIMIT;
        end else begin
            st  = (pidx(tgt) - pidx(s) + 7) % 7;
            q   = tgt;
            hit = 1'b1;
        end
        lat = st + 3;
    endtask

    // Entered and left at a negedge. lat counts sampled cycles after the
    // accepting edge (the LOAD cycle is 1).
    task automatic run_cmd(input logic mode, input logic [2:0] seed, input int steps,
                           input logic [2:0] tgt, output int lat, output logic [2:0] q,
                           output logic hit, output int st, output bit ok);
        int t;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        cmd_valid  = 1'b1;
        cmd_mode   = mode;
        cmd_seed   = seed;
        cmd_steps  = STEP_W'(steps);
        cmd_target = tgt;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("load_l", int'(lfsr_l), 1);
        lat = 1;
        while (!res_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        ok  = res_valid;
        q   = res_q;
        hit = res_hit;
        st  = int'(res_steps);
    endtask

    task automatic consume(input int hold);
        logic [2:0]        q0, r0;
        logic              h0;
        logic [STEP_W-1:0] s0;
        q0 = res_q; h0 = res_hit; s0 = res_steps; r0 = lfsr_q;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid", int'(res_valid), 1);
            check("bp_res_q", int'(res_q), int'(q0));
            check("bp_res_hit", int'(res_hit), int'(h0));
            check("bp_res_steps", int'(res_steps), int'(s0));
            check("bp_lfsr_q", int'(lfsr_q), int'(r0));
            check("bp_cmd_ready", int'(cmd_ready), 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("idle_cmd_ready", int'(cmd_ready), 1);
        check("idle_res_valid", int'(res_valid), 0);
    endtask

    typedef struct {
        logic       mode;
        logic [2:0] seed;
        int         steps;
        logic [2:0] tgt;
        logic [2:0] eq;
        logic       eh;
        int         est;
        int         elat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int         lat, st, est, elat;
        logic [2:0] q, eq, sd, tg;
        logic       hit, eh, md;
        bit         ok;
        int         stp;

        vecs[0] = '{1'b0, 3'b001, 3,  3'b000, 3'b101, 1'b0, 3, 6};
        vecs[1] = '{1'b0, 3'b000, 0,  3'b000, 3'b001, 1'b0, 0, 3};
        vecs[2] = '{1'b1, 3'b001, 0,  3'b110, 3'b110, 1'b1, 6, 9};
        vecs[3] = '{1'b1, 3'b101, 0,  3'b000, 3'b101, 1'b0, 7, 10};
        vecs[4] = '{1'b1, 3'b011, 0,  3'b011, 3'b011, 1'b1, 0, 3};
        vecs[5] = '{1'b0, 3'b110, 10, 3'b000, 3'b100, 1'b0, 10, 13};
        vecs[6] = '{1'b1, 3'b000, 0,  3'b001, 3'b001, 1'b1, 0, 3};

        for (int i = 0; i < 7; i++)
            check("pkg_lfsr_next", int'(lfsr_next(period[i])), int'(period[(i + 1) % 7]));

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_lfsr_l", int'(lfsr_l), 1);
        check("rst_lfsr_r", int'(lfsr_r), int'(lfsr_q));
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_q", int'(res_q), 0);
        check("rst_res_hit", int'(res_hit), 0);
        check("rst_res_steps", int'(res_steps), 0);
        @(negedge clk);
        check("idle_hold_q", int'(lfsr_q), 3'b011);

        for (int i = 0; i < 7; i++) begin
            run_cmd(vecs[i].mode, vecs[i].seed, vecs[i].steps, vecs[i].tgt, lat, q, hit, st, ok);
            check("vec_timeout", int'(ok), 1);
            check("vec_res_q", int'(q), int'(vecs[i].eq));
            check("vec_res_hit", int'(hit), int'(vecs[i].eh));
            check("vec_res_steps", st, vecs[i].est);
            check("vec_latency", lat, vecs[i].elat);
            check("done_lfsr_l", int'(lfsr_l), 1);
            check("done_lfsr_r", int'(lfsr_r), int'(lfsr_q));
            consume(i == 0 ? 5 : 0);
        end

        // Reset in the middle of a run: register keeps its value.
        cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_seed = 3'b001; cmd_steps = 8'd5;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rr_q_shift0", int'(lfsr_q), 3'b001);
        @(negedge clk);
        check("rr_q_shift1", int'(lfsr_q), 3'b010);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rr_lfsr_l", int'(lfsr_l), 1);
        check("rr_lfsr_q", int'(lfsr_q), 3'b100);
        check("rr_res_valid", int'(res_valid), 0);
        check("rr_cmd_ready", int'(cmd_ready), 1);
        @(negedge clk);
        check("rr_lfsr_q_held", int'(lfsr_q), 3'b100);

        for (int n = 0; n < 40; n++) begin
            md  = 1'($urandom_range(0, 1));
            sd  = 3'($urandom_range(0, 7));
            tg  = 3'($urandom_range(0, 7));
            stp = int'($urandom_range(0, 20));
            ref_model(md, sd, stp, tg, eq, eh, est, elat);
            run_cmd(md, sd, stp, tg, lat, q, hit, st, ok);
            check("rnd_timeout", int'(ok), 1);
            check("rnd_res_q", int'(q), int'(eq));
            check("rnd_res_hit", int'(hit), int'(eh));
            check("rnd_res_steps", st, est);
            check("rnd_latency", lat, elat);
            consume(int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
